block_uart_tx: RTL and testbench

//  Return path of the secure-link UART. Accepts one 128-bit block (e.g. DES/msg result) via valid/ready,

---
 rtl/block_uart_tx.sv | 129 ++++++++++++
 tb/tb_block_uart_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/block_uart_tx.sv
// Serialises one accepted block into BYTES_PER_BLOCK 8N1 UART frames, MSB byte first,
// so the matching RX chain rebuilds the identical block.
module block_uart_tx #(
    parameter int CLKS_PER_BIT    = 868,
    parameter int BYTES_PER_BLOCK = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [8*BYTES_PER_BLOCK-1:0] block_in,
    input  logic                         block_valid,
    output logic                         block_ready,
    output logic                         UART_TX,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int BLK_W  = 8 * BYTES_PER_BLOCK;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_BLOCK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   shreg_q, shreg_d;
    logic [BYTE_W-1:0]  byte_idx_q, byte_idx_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic               tx_q, tx_d;

    logic               accept;
    logic               baud_wrap;
    logic [7:0]         cur_byte;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            baud_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        baud_d     = baud_q;
        accept     = block_valid && block_ready;
        baud_wrap  = (baud_q == BAUD_MAX);

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    state_d    = S_START;
                    shreg_d    = block_in;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    baud_d     = '0;
                end
            end
            S_START: begin
                baud_d = baud_q + BAUD_W'(1);
                if (baud_wrap) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                baud_d = baud_q + BAUD_W'(1);
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_STOP: begin
                baud_d = baud_q + BAUD_W'(1);
                if (baud_wrap) begin
                    baud_d = '0;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = S_DONE;
                    end else begin
                        // Next byte moves to the top of the shift register; no idle gap.
                        byte_idx_d = byte_idx_q + BYTE_W'(1);
                        shreg_d    = shreg_q << 8;
                        state_d    = S_START;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is computed from the next state so the registered pin lines up with it.
        cur_byte = shreg_d[BLK_W-1 -: 8];
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_byte[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        block_ready = (state_q == S_IDLE) || (state_q == S_DONE);
        o_busy      = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
        o_done      = (state_q == S_DONE);
        UART_TX     = tx_q;
    end

endmodule

// File: tb/tb_block_uart_tx.sv
// Bench for block_uart_tx: a negedge monitor decodes every frame cycle-exactly against a
// byte scoreboard filled at accept time, and checks accept-to-done latency.
module tb_block_uart_tx;

    localparam int CPB   = 4;
    localparam int NB    = 16;
    localparam int FRAME = 10 * CPB;
    localparam int LAT   = 160 * CPB + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [127:0] block_in = '0;
    logic         block_valid = 1'b0;
    logic         block_ready, UART_TX, o_busy, o_done;

    block_uart_tx #(.CLKS_PER_BIT(CPB), .BYTES_PER_BLOCK(NB)) dut (
        .clk(clk), .reset(reset), .block_in(block_in), .block_valid(block_valid),
        .block_ready(block_ready), .UART_TX(UART_TX), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct { logic [7:0] b; bit last; } exp_byte_t;
    exp_byte_t byte_q[$];
    int        done_q[$];
    int        epoch = 0;
    int        cyc = 0;
    int        frames_ok = 0;
    bit        in_frame = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: accept detection, frame decoding, done latency.
    initial begin
        bit          acc_prev = 0;
        int          fcnt = 0;
        int          fepoch = 0;
        int          fstart = 0;
        int          last_start = 0;
        int          last_epoch = -1;
        bit          last_was_last = 1;
        logic [39:0] obs = '0;
        logic [39:0] expv;
        logic [9:0]  fb;
        exp_byte_t   e;
        forever begin
            @(negedge clk);
            cyc++;
            if (in_frame && fepoch != epoch) in_frame = 0;
            if (acc_prev) chk("start_after_accept", {61'd0, UART_TX, o_busy, block_ready}, 64'b010);
            acc_prev = 0;
            if (reset && block_valid && block_ready) begin
                for (int i = 0; i < NB; i++) begin
                    e.b = block_in[127-8*i -: 8];
                    e.last = (i == NB - 1);
                    byte_q.push_back(e);
                end
                done_q.push_back(cyc + LAT);
                acc_prev = 1;
            end
            if (reset && o_done === 1'b1) begin
                chk("done_flags", {62'd0, o_busy, block_ready}, 64'b01);
                if (done_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
                else chk("done_latency", 64'(cyc), 64'(done_q.pop_front()));
            end
            if (reset && o_busy === 1'b1 && block_valid) chk("ready_low_busy", 64'(block_ready), 64'd0);
            if (!in_frame && UART_TX === 1'b0) begin
                in_frame = 1; fcnt = 0; fepoch = epoch; fstart = cyc;
                if (last_epoch == epoch && !last_was_last)
                    chk("no_gap", 64'(cyc), 64'(last_start + FRAME));
            end
            if (in_frame) begin
                obs[fcnt] = UART_TX;
                fcnt++;
                if (fcnt == FRAME) begin
                    in_frame = 0;
                    if (byte_q.size() == 0) begin
                        chk("frame_unexpected", 64'(obs), 64'd0);
                    end else begin
                        e = byte_q.pop_front();
                        fb = {1'b1, e.b, 1'b0};
                        for (int c = 0; c < FRAME; c++) expv[c] = fb[c / CPB];
                        chk("frame", 64'(obs), 64'(expv));
                        last_was_last = e.last;
                    end
                    last_start = fstart; last_epoch = fepoch;
                    frames_ok++;
                end
            end
        end
    end

    task automatic send(input logic [127:0] d);
        int n = 0;
        @(posedge clk); #1;
        block_in = d; block_valid = 1'b1;
        while (!block_ready && n < 2000) begin @(posedge clk); #1; n++; end
        if (n >= 2000) chk("send_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        block_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin @(posedge clk); #1; n++; end
        while (!(byte_q.size() == 0 && done_q.size() == 0 && !in_frame && !o_busy && !o_done) && n < 3000);
        if (n >= 3000) chk("drain_timeout", 64'(n), 64'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] x, y;
        int f0, n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {60'd0, UART_TX, block_ready, o_busy, o_done}, 64'b1100);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // T1: counting bytes, latency checked by monitor
        send(128'h00112233445566778899AABBCCDDEEFF);
        drain();

        // T2: A5 frames among others
        send(128'hA5A5_5A5A_A5FF_0080_01A5_7E81_C3A5_3CA5);
        drain();

        // T3: back-to-back with valid held high
        f0 = frames_ok;
        x = rnd128(); y = rnd128();
        @(posedge clk); #1;
        block_in = x; block_valid = 1'b1;
        @(posedge clk); #1;
        block_in = y;
        n = 0;
        while (!block_ready && n < 2000) begin @(posedge clk); #1; n++; end
        chk("b2b_accept_in_done", {62'd0, block_ready, o_done}, 64'b11);
        @(posedge clk); #1;
        block_valid = 1'b0;
        drain();
        chk("b2b_byte_count", 64'(frames_ok - f0), 64'd32);

        // T4: input changes and valid pulse while busy are ignored
        x = rnd128();
        send(x);
        repeat (100) @(posedge clk);
        #1;
        block_in = ~x; block_valid = 1'b1;
        @(posedge clk); #1;
        block_valid = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        block_in = 128'h0; block_valid = 1'b1;
        @(posedge clk); #1;
        block_valid = 1'b0;
        drain();

        // T5: one-cycle reset in the middle of byte 5 data bits
        send(rnd128());
        repeat (209) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        byte_q.delete(); done_q.delete(); epoch++;
        chk("mid_reset_state", {60'd0, UART_TX, block_ready, o_busy, o_done}, 64'b1100);
        repeat (50) @(posedge clk);
        send(rnd128());
        drain();

        // random blocks
        for (int i = 0; i < 3; i++) begin
            send(rnd128());
            drain();
        end

        chk("bytes_left", 64'(byte_q.size()), 64'd0);
        chk("dones_left", 64'(done_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
